// File: rtl/dlx_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : dlx_issue_stage
// Purpose  : DLX decode/issue stage feeding the integer ALU and writeback.
//            Optional ILLEGAL_TRAP_EN makes an illegal instruction a sticky trap.
// Revision : 1.0
// ============================================================================
module dlx_issue_stage #(
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    output logic [3:0]        alu_i,
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    output logic              alu_ex,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [5:0]        opcode, func;
    logic [3:0]        dec_code;
    logic              dec_legal, dec_imm, dec_zext, dec_lhi;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [31:0]       dec_immval;
    logic              accept, drop;
    logic              trap_q;
    logic              unused_bits;

    logic [3:0]        code_q;
    logic [REG_AW-1:0] rd_q;
    logic [31:0]       imm_q, op1_q, op2_q;
    logic              is_imm_q, lhi_q, rs1z_q, rs2z_q, illegal_q;

    assign opcode      = in_instr[31:26];
    assign func        = in_instr[5:0];
    assign dec_rs1     = REG_AW'(in_instr[25:21]);
    assign dec_rs2     = REG_AW'(in_instr[20:16]);
    assign unused_bits = ^in_instr[10:6];

    always_comb begin
        dec_code  = 4'd0;
        dec_legal = 1'b1;
        dec_imm   = 1'b1;
        dec_zext  = 1'b0;
        dec_lhi   = 1'b0;
        if (opcode == 6'h00) begin
            dec_imm = 1'b0;
            case (func)
                6'h20: dec_code = 4'd1;
                6'h22: dec_code = 4'd2;
                6'h24: dec_code = 4'd3;
                6'h25: dec_code = 4'd4;
                6'h26: dec_code = 4'd5;
                6'h04: dec_code = 4'd6;
                6'h06: dec_code = 4'd7;
                6'h07: dec_code = 4'd14;
                6'h28: dec_code = 4'd10;
                6'h29: dec_code = 4'd13;
                6'h2A: dec_code = 4'd12;
                6'h2C: dec_code = 4'd11;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08: dec_code = 4'd1;
                6'h0A: dec_code = 4'd2;
                6'h14: dec_code = 4'd6;
                6'h16: dec_code = 4'd7;
                6'h17: dec_code = 4'd14;
                6'h18: dec_code = 4'd10;
                6'h19: dec_code = 4'd13;
                6'h1A: dec_code = 4'd12;
                6'h1C: dec_code = 4'd11;
                6'h0C: begin dec_code = 4'd3; dec_zext = 1'b1; end
                6'h0D: begin dec_code = 4'd4; dec_zext = 1'b1; end
                6'h0E: begin dec_code = 4'd5; dec_zext = 1'b1; end
                6'h0F: begin dec_code = 4'd0; dec_zext = 1'b1; dec_lhi = 1'b1; end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // R-type writes rd from [15:11]; I-type reuses the rs2 field as rd.
    assign dec_rd     = dec_imm ? REG_AW'(in_instr[20:16]) : REG_AW'(in_instr[15:11]);
    assign dec_immval = dec_zext ? {{(32-IMM_W){1'b0}}, in_instr[IMM_W-1:0]}
                                 : {{(32-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        alu_ex   = 1'b0;
        wb_valid = 1'b0;
        accept   = 1'b0;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~trap_q;
                if (in_valid && !trap_q) begin
                    if (dec_legal) begin
                        accept  = 1'b1;
                        state_d = READ;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            READ:  state_d = ISSUE;
            ISSUE: begin
                alu_ex  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file is only addressed for an accepted, decodable instruction.
    assign rf_raddr1 = accept ? dec_rs1 : '0;
    assign rf_raddr2 = accept ? dec_rs2 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            is_imm_q  <= 1'b0;
            lhi_q     <= 1'b0;
            rs1z_q    <= 1'b0;
            rs2z_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= drop;
            if (accept) begin
                code_q   <= dec_code;
                rd_q     <= dec_rd;
                imm_q    <= dec_immval;
                is_imm_q <= dec_imm;
                lhi_q    <= dec_lhi;
                rs1z_q   <= (dec_rs1 == '0);
                rs2z_q   <= (dec_rs2 == '0);
            end
            if (state_q == READ) begin
                op1_q <= (lhi_q || rs1z_q) ? 32'd0 : rf_rdata1;
                op2_q <= is_imm_q ? imm_q : (rs2z_q ? 32'd0 : rf_rdata2);
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)       trap_q <= 1'b0;
        else if (drop) trap_q <= 1'b1;
    end
`else
    assign trap_q = 1'b0;
`endif

    assign alu_i   = code_q;
    assign alu_op1 = op1_q;
    assign alu_op2 = op2_q;
    assign wb_rd   = rd_q;
    assign wb_we   = wb_valid && (rd_q != '0);
    assign illegal = illegal_q | trap_q;

endmodule
`default_nettype wire
